// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Instruction-memory request/response bundle between the
//                fetch stage (master) and instruction memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    logic        imem_req;     // one-cycle request strobe, always accepted
    logic [31:0] imem_addr;    // request address
    logic        imem_rvalid;  // response valid, once per request, in order
    logic [31:0] imem_rdata;   // response word

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : RV32I instruction fetch with IF/ID pipeline register.
//                Single outstanding imem request, decode stall handling via
//                a one-word hold buffer, and EX redirects that drain any
//                response still in flight for a killed request.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        stall,
    input  wire logic        redirect,
    input  wire logic [31:0] redirect_pc,
    fetch_stage_if.master    imem,
    output logic      [31:0] instr_out,
    output logic      [31:0] pc_out,
    output logic             instr_valid
);

    // FETCH: request on the bus this cycle
    // WAIT : request outstanding, response not yet seen
    // HOLD : response captured while decode was stalled
    // DRAIN: outstanding response belongs to a killed request
    localparam logic [1:0] c_FETCH = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold_buf;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_valid;
    logic [31:0] w_pc_plus4;

    // Sequential PC increment wraps naturally at 32 bits.
    assign w_pc_plus4 = r_pc + 32'd4;

    // Request strobe is masked by reset so nothing is issued while held.
    assign imem.imem_req  = (r_state == c_FETCH) && rst_n;
    assign imem.imem_addr = r_pc;

    assign instr_out   = r_instr;
    assign pc_out      = r_pc_out;
    assign instr_valid = r_valid;

    // Fetch FSM, PC, hold buffer and IF/ID register; redirect outranks
    // stall and response, and a non-stalled cycle with nothing to deliver
    // loads a bubble while pc_out keeps its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_FETCH;
            r_pc       <= RESET_PC;
            r_hold_buf <= 32'd0;
            r_instr    <= NOP_INSTR;
            r_pc_out   <= RESET_PC;
            r_valid    <= 1'b0;
        end else if (redirect) begin
            r_pc    <= redirect_pc;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            case (r_state)
                c_FETCH: r_state <= c_DRAIN;
                c_WAIT:  r_state <= imem.imem_rvalid ? c_FETCH : c_DRAIN;
                c_HOLD:  r_state <= c_FETCH;
                default: r_state <= imem.imem_rvalid ? c_FETCH : c_DRAIN;
            endcase
        end else begin
            case (r_state)
                c_FETCH: begin
                    r_state <= c_WAIT;
                    if (!stall) begin
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end
                end
                c_WAIT: begin
                    if (imem.imem_rvalid && !stall) begin
                        r_instr  <= imem.imem_rdata;
                        r_pc_out <= r_pc;
                        r_valid  <= 1'b1;
                        r_pc     <= w_pc_plus4;
                        r_state  <= c_FETCH;
                    end else if (imem.imem_rvalid) begin
                        r_hold_buf <= imem.imem_rdata;
                        r_state    <= c_HOLD;
                    end else if (!stall) begin
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end
                end
                c_HOLD: begin
                    if (!stall) begin
                        r_instr  <= r_hold_buf;
                        r_pc_out <= r_pc;
                        r_valid  <= 1'b1;
                        r_pc     <= w_pc_plus4;
                        r_state  <= c_FETCH;
                    end
                end
                default: begin
                    if (imem.imem_rvalid) begin
                        r_state <= c_FETCH;
                    end
                    if (!stall) begin
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage. A small
//                latency-configurable memory answers addr|0x13; some
//                scenarios drive the response lines by hand instead.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;

    // memory model controls and outputs
    logic        mem_en;
    int          mem_lat;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    // hand-driven response
    logic        man_rvalid;
    logic [31:0] man_rdata;

    int checks = 0;
    int errors = 0;

    fetch_stage_if imem ();

    assign imem.imem_rvalid = mem_en ? mem_rvalid : man_rvalid;
    assign imem.imem_rdata  = mem_en ? mem_rdata  : man_rdata;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem.master),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    // Memory model: a request seen in a cycle is answered mem_lat cycles later.
    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 1'b0; cnt = 0; paddr = 32'd0;
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (!mem_en) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cnt = cnt - 1;
                    if (cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = paddr | 32'h13;
                        pend       = 1'b0;
                    end
                end
                if (imem.imem_req) begin
                    pend  = 1'b1;
                    cnt   = mem_lat;
                    paddr = imem.imem_addr;
                end
            end
        end
    end

    // Advance one edge and settle; observations reflect state after that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; mem_en = 1'b0; man_rvalid = 1'b0; man_rdata = 32'd0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_en = 1'b0; mem_lat = 1; man_rvalid = 1'b0; man_rdata = 32'd0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        tick();
        tick();
        checks++;
        if (instr_out !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h exp %h", instr_out, 32'h13); end
        checks++;
        if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h exp %h", pc_out, 32'h0); end
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
        checks++;
        if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req_low: got %b exp 0", imem.imem_req); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin
            errors++; $display("FAIL release_req: got req=%b addr=%h exp req=1 addr=0", imem.imem_req, imem.imem_addr);
        end
    endtask

    // Continues straight from test_reset: 1-cycle memory.
    task automatic test_free_run();
        mem_lat = 1; mem_en = 1'b1;
        tick(); // edge1: WAIT
        checks++;
        if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL fr_wait_req: got %b exp 0", imem.imem_req); end
        tick(); // edge2: first instruction delivered
        checks++;
        if (instr_out !== 32'h13 || pc_out !== 32'h0 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL fr_first: got %h/%h/%b exp 00000013/00000000/1", instr_out, pc_out, instr_valid);
        end
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h4) begin
            errors++; $display("FAIL fr_addr4: got req=%b addr=%h exp req=1 addr=4", imem.imem_req, imem.imem_addr);
        end
        tick(); // edge3: bubble
        checks++;
        if (instr_valid !== 1'b0 || instr_out !== 32'h13 || pc_out !== 32'h0) begin
            errors++; $display("FAIL fr_bubble: got %h/%h/%b exp 00000013/00000000/0", instr_out, pc_out, instr_valid);
        end
        tick(); // edge4: second instruction
        checks++;
        if (instr_out !== 32'h17 || pc_out !== 32'h4 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL fr_second: got %h/%h/%b exp 00000017/00000004/1", instr_out, pc_out, instr_valid);
        end
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h8) begin
            errors++; $display("FAIL fr_addr8: got req=%b addr=%h exp req=1 addr=8", imem.imem_req, imem.imem_addr);
        end
    endtask

    // Continues from free-run: request for PC 8 is on the bus now.
    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instr_out !== 32'h17 || pc_out !== 32'h4 || instr_valid !== 1'b1 || imem.imem_req !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d]: got %h/%h/%b req=%b exp 00000017/00000004/1 req=0",
                                   i, instr_out, pc_out, instr_valid, imem.imem_req);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (instr_out !== 32'h1b || pc_out !== 32'h8 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL stall_release: got %h/%h/%b exp 0000001b/00000008/1", instr_out, pc_out, instr_valid);
        end
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'hc) begin
            errors++; $display("FAIL stall_next_addr: got req=%b addr=%h exp req=1 addr=c", imem.imem_req, imem.imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        mem_lat = 3; mem_en = 1'b1;
        repeat (8) tick(); // PC 0 and PC 4 delivered, request for PC 8 on bus
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h8 || pc_out !== 32'h4 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL rw_setup: got req=%b addr=%h pc_out=%h v=%b exp req=1 addr=8 pc_out=4 v=1",
                               imem.imem_req, imem.imem_addr, pc_out, instr_valid);
        end
        tick(); // WAIT for PC 8
        redirect = 1'b1; redirect_pc = 32'h100;
        tick(); // redirect taken, DRAIN
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr_out !== 32'h13 || pc_out !== 32'h4 || imem.imem_req !== 1'b0) begin
            errors++; $display("FAIL rw_flush: got %h/%h/%b req=%b exp 00000013/00000004/0 req=0",
                               instr_out, pc_out, instr_valid, imem.imem_req);
        end
        tick(); // still draining, response arrives this cycle
        checks++;
        if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rw_drain_req: got %b exp 0", imem.imem_req); end
        tick(); // drained
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h100) begin
            errors++; $display("FAIL rw_target: got req=%b addr=%h exp req=1 addr=100", imem.imem_req, imem.imem_addr);
        end
        checks++;
        if (instr_valid !== 1'b0 || instr_out !== 32'h13) begin
            errors++; $display("FAIL rw_discard: got %h/%b exp 00000013/0", instr_out, instr_valid);
        end
    endtask

    task automatic test_redirect_rvalid_stall();
        apply_reset();
        tick(); // WAIT for PC 0
        man_rvalid = 1'b1; man_rdata = 32'h0000_0093;
        tick(); // delivered {93,0,1}, FETCH PC 4
        man_rvalid = 1'b0;
        tick(); // WAIT for PC 4
        man_rvalid = 1'b1; man_rdata = 32'hdead_beef;
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        man_rvalid = 1'b0; stall = 1'b0; redirect = 1'b0;
        checks++;
        if (instr_out !== 32'h13 || instr_valid !== 1'b0 || pc_out !== 32'h0) begin
            errors++; $display("FAIL rrs_flush: got %h/%h/%b exp 00000013/00000000/0", instr_out, pc_out, instr_valid);
        end
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h200) begin
            errors++; $display("FAIL rrs_target: got req=%b addr=%h exp req=1 addr=200", imem.imem_req, imem.imem_addr);
        end
        tick();
        checks++;
        if (instr_out !== 32'h13 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL rrs_dropped: got %h/%b exp 00000013/0", instr_out, instr_valid);
        end
    endtask

    task automatic test_pc_wrap();
        apply_reset();
        mem_lat = 1; mem_en = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hffff_fffc;
        tick(); // FETCH + redirect -> DRAIN
        redirect = 1'b0;
        tick(); // PC 0 response drained
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'hffff_fffc) begin
            errors++; $display("FAIL wrap_target: got req=%b addr=%h exp req=1 addr=fffffffc", imem.imem_req, imem.imem_addr);
        end
        tick();
        tick();
        checks++;
        if (instr_out !== 32'hffff_ffff || pc_out !== 32'hffff_fffc || instr_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_instr: got %h/%h/%b exp ffffffff/fffffffc/1", instr_out, pc_out, instr_valid);
        end
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_addr: got req=%b addr=%h exp req=1 addr=0", imem.imem_req, imem.imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        tick(); // WAIT for PC 0
        man_rvalid = 1'b1; man_rdata = 32'h0000_0093;
        tick(); // delivered, FETCH PC 4
        man_rvalid = 1'b0;
        tick(); // WAIT for PC 4
        rst_n = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hcafe_0013;
        #1;
        checks++;
        if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rm_req_in_reset: got %b exp 0", imem.imem_req); end
        tick(); // reset edge
        rst_n = 1'b1; // late response held high into the first FETCH cycle
        #1;
        checks++;
        if (instr_out !== 32'h13 || pc_out !== 32'h0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL rm_outputs: got %h/%h/%b exp 00000013/00000000/0", instr_out, pc_out, instr_valid);
        end
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin
            errors++; $display("FAIL rm_release: got req=%b addr=%h exp req=1 addr=0", imem.imem_req, imem.imem_addr);
        end
        tick(); // FETCH -> WAIT, late response ignored
        checks++;
        if (instr_valid !== 1'b0 || instr_out !== 32'h13) begin
            errors++; $display("FAIL rm_late_ignored: got %h/%b exp 00000013/0", instr_out, instr_valid);
        end
        man_rdata = 32'h0000_0113;
        tick();
        man_rvalid = 1'b0;
        checks++;
        if (instr_out !== 32'h113 || pc_out !== 32'h0 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL rm_refetch: got %h/%h/%b exp 00000113/00000000/1", instr_out, pc_out, instr_valid);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid_stall();
        test_pc_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so a stuck scenario still ends with a summary.
    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
